// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop, one bit
// per clock, LSB first; {bout, d} = a - b - bin once done pulses.
//
// state | meaning
// IDLE  | waiting for start; d/bout hold the last result
// SHIFT | one difference bit per cycle, busy high
// DONE  | result valid for one cycle, done high; start here chains a new op
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout
);

   // Counter reaches WIDTH at most, so it never wraps mid-operation.
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             bout_q, bout_d;

   logic             diff_bit;
   logic             borrow_next;

   // Full-subtractor cell on the current LSBs of the operand shift registers.
   assign diff_bit    = a_q[0] ^ b_q[0] ^ borrow_q;
   assign borrow_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      d_d      = d_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      busy_d   = busy_q;
      done_d   = done_q;
      bout_d   = bout_q;

      case (state_q)
         IDLE: begin
            done_d = 1'b0;
            if (start) begin
               a_d      = a;
               b_d      = b;
               borrow_d = bin;
               res_d    = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = SHIFT;
            end
         end

         SHIFT: begin
            a_d              = a_q >> 1;
            b_d              = b_q >> 1;
            res_d            = res_q >> 1;
            res_d[WIDTH-1]   = diff_bit;
            borrow_d         = borrow_next;
            cnt_d            = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               d_d     = res_d;
               bout_d  = borrow_next;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end

         DONE: begin
            done_d = 1'b0;
            if (start) begin
               a_d      = a;
               b_d      = b;
               borrow_d = bin;
               res_d    = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = SHIFT;
            end else begin
               state_d  = IDLE;
            end
         end

         default: begin
            busy_d  = 1'b0;
            done_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         d_q      <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         d_q      <= d_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         bout_q   <= bout_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign d    = d_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, back-to-back,
// operand changes in flight, reset abort and an exhaustive 4-bit sweep.
module tb_serial_subtractor;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bout;

   int checks   = 0;
   int failures = 0;
   logic [W:0] exp_last;   // {bout, d} the outputs must currently hold

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .bin  (bin),
      .busy (busy),
      .done (done),
      .d    (d),
      .bout (bout)
   );

   function automatic logic [W:0] ref_sub(input int av, input int bv, input int cv);
      int r;
      r = av - bv - cv + 64;
      return r[W:0];
   endfunction

   // Drives one start pulse and waits (bounded) for done.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         output logic [W-1:0] rd, output logic rbout,
                         output int busy_cnt, output int lat, output logic ok,
                         output logic done_after);
      @(negedge clk);
      a = av; b = bv; bin = cv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0; busy_cnt = 0; ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (done) begin ok = 1'b1; break; end
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      rd = d; rbout = bout;
      @(negedge clk);
      done_after = done;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a = '1; b = '1; bin = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, bout, d} !== '0) begin
         failures++;
         $display("FAIL reset_state got busy=%b done=%b d=%b bout=%b exp all 0", busy, done, d, bout);
      end
      rst = 1'b0; a = 4'b0010; b = 4'b0001; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL start_after_reset got busy=%b exp 1", busy);
      end
      exp_last = '0;
      for (int c = 0; c < 20 && !done; c++) @(negedge clk);
      checks++;
      if (done !== 1'b1 || {bout, d} !== ref_sub(2, 1, 0)) begin
         failures++;
         $display("FAIL first_op got done=%b res=%b exp done=1 res=%b", done, {bout, d}, ref_sub(2, 1, 0));
      end
      exp_last = ref_sub(2, 1, 0);
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [W-1:0] av [3] = '{4'b0010, 4'b0000, 4'b0101};
      logic [W-1:0] bv [3] = '{4'b0001, 4'b0001, 4'b0011};
      logic         cv [3] = '{1'b0, 1'b0, 1'b1};
      logic [W-1:0] rd;
      logic rbout, ok, dn_after;
      int bc, lat;
      for (int i = 0; i < 3; i++) begin
         run_op(av[i], bv[i], cv[i], rd, rbout, bc, lat, ok, dn_after);
         checks++;
         if (!ok || {rbout, rd} !== ref_sub(av[i], bv[i], cv[i])) begin
            failures++;
            $display("FAIL directed_%0d got done=%b res=%b exp res=%b", i, ok, {rbout, rd}, ref_sub(av[i], bv[i], cv[i]));
         end
         checks++;
         if (bc !== W || lat !== W) begin
            failures++;
            $display("FAIL directed_timing_%0d got busy_cycles=%0d latency=%0d exp %0d/%0d", i, bc, lat, W, W);
         end
         checks++;
         if (dn_after !== 1'b0) begin
            failures++;
            $display("FAIL done_width_%0d got done=%b one cycle later exp 0", i, dn_after);
         end
         exp_last = ref_sub(av[i], bv[i], cv[i]);
      end
   endtask

   task automatic test_back_to_back();
      int           t_done[$];
      logic [W:0]   res[$];
      @(negedge clk);
      a = 4'b1000; b = 4'b0001; bin = 1'b0; start = 1'b1;
      for (int c = 0; c < 30 && t_done.size() < 2; c++) begin
         @(negedge clk);
         if (c == 0) begin a = 4'b0011; b = 4'b0111; end
         if (done) begin
            t_done.push_back(c);
            res.push_back({bout, d});
            if (t_done.size() == 2) start = 1'b0;
         end
      end
      start = 1'b0;
      checks++;
      if (t_done.size() != 2) begin
         failures++;
         $display("FAIL b2b_done_count got=%0d exp=2", t_done.size());
      end else begin
         checks++;
         if (res[0] !== ref_sub(8, 1, 0)) begin
            failures++;
            $display("FAIL b2b_first got=%b exp=%b", res[0], ref_sub(8, 1, 0));
         end
         checks++;
         if (res[1] !== ref_sub(3, 7, 0)) begin
            failures++;
            $display("FAIL b2b_second got=%b exp=%b", res[1], ref_sub(3, 7, 0));
         end
         checks++;
         if (t_done[1] - t_done[0] != W + 1) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d exp=%0d", t_done[1] - t_done[0], W + 1);
         end
      end
      exp_last = ref_sub(3, 7, 0);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle got busy=%b done=%b exp 0/0", busy, done);
      end
   endtask

   task automatic test_operand_change();
      logic [W-1:0] av, bv;
      logic         cv, seen, hold_ok;
      logic [W:0]   exp;
      int           lat;
      for (int it = 0; it < 6; it++) begin
         av = W'($urandom); bv = W'($urandom); cv = 1'($urandom);
         exp = ref_sub(av, bv, cv);
         @(negedge clk);
         a = av; b = bv; bin = cv; start = 1'b1;
         seen = 1'b0; hold_ok = 1'b1; lat = -1;
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; lat = c; start = 1'b0; break; end
            if ({bout, d} !== exp_last) hold_ok = 1'b0;
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            start = (c == 0 || c == 2);
         end
         start = 1'b0;
         checks++;
         if (!seen || lat != W || {bout, d} !== exp) begin
            failures++;
            $display("FAIL operand_change_%0d got done=%b lat=%0d res=%b exp lat=%0d res=%b", it, seen, lat, {bout, d}, W, exp);
         end
         checks++;
         if (!hold_ok) begin
            failures++;
            $display("FAIL hold_during_shift_%0d got outputs changed exp held %b", it, exp_last);
         end
         exp_last = exp;
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL ignored_start_%0d got busy=%b done=%b exp 0/0", it, busy, done);
         end
      end
   endtask

   task automatic test_reset_mid_shift();
      logic [W-1:0] rd;
      logic rbout, ok, dn_after, stray;
      int bc, lat;
      run_op(4'b0000, 4'b0001, 1'b0, rd, rbout, bc, lat, ok, dn_after);
      exp_last = ref_sub(0, 1, 0);
      @(negedge clk);
      a = 4'b0101; b = 4'b0011; bin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, bout, d} !== '0) begin
         failures++;
         $display("FAIL reset_abort got busy=%b done=%b d=%b bout=%b exp all 0", busy, done, d, bout);
      end
      exp_last = '0;
      stray = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) stray = 1'b1;
      end
      checks++;
      if (stray) begin
         failures++;
         $display("FAIL reset_no_done got activity after abort exp none");
      end
      run_op(4'b1001, 4'b0100, 1'b0, rd, rbout, bc, lat, ok, dn_after);
      checks++;
      if (!ok || {rbout, rd} !== ref_sub(9, 4, 0)) begin
         failures++;
         $display("FAIL after_abort got done=%b res=%b exp res=%b", ok, {rbout, rd}, ref_sub(9, 4, 0));
      end
      exp_last = ref_sub(9, 4, 0);
   endtask

   task automatic test_sweep();
      logic [W-1:0] rd;
      logic rbout, ok, dn_after;
      int bc, lat;
      for (int av = 0; av < 16; av++)
         for (int bv = 0; bv < 16; bv++)
            for (int cv = 0; cv < 2; cv++) begin
               run_op(W'(av), W'(bv), 1'(cv), rd, rbout, bc, lat, ok, dn_after);
               checks++;
               if (!ok || lat != W || {rbout, rd} !== ref_sub(av, bv, cv)) begin
                  failures++;
                  $display("FAIL sweep a=%0d b=%0d bin=%0d got done=%b lat=%0d res=%b exp res=%b",
                           av, bv, cv, ok, lat, {rbout, rd}, ref_sub(av, bv, cv));
               end
            end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0; exp_last = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_operand_change();
      test_reset_mid_shift();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
